mcu_bus_controller: RTL and testbench
=====================================

Name: mcu_bus_controller

Overview:
- Parametrised data-side bus controller between the CPU core and data storage/IO in the MCU.
- Replaces the combinational data-memory hookup with a registered, handshaked bus:
  - internal synchronous RAM with configurable wait states
  - memory-mapped input ports (switch input, keypad)
  - NUM_OUT memory-mapped output registers (display digits).
- The CPU stalls on cpu_req until cpu_ack.

Parameters:
- BUS_WIDTH, 8, data and address width.
- DM_DEPTH, 128, RAM words at addresses 0..DM_DEPTH-1; must be <= IO_BASE.
- IO_BASE, 8'hF0, base address of the IO window.
- NUM_OUT, 2, number of output registers at IO_BASE..IO_BASE+NUM_OUT-1; 1..14.
- WAIT_STATES, 1, extra cycles per RAM access; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  access request; held until cpu_ack.
- cpu_mw  input  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  input  BUS_WIDTH  access address.
- cpu_wdata  input  BUS_WIDTH  write data.
- cpu_rdata  output  BUS_WIDTH  read data, valid when cpu_ack=1.
- cpu_ack  output  1  one-cycle completion pulse.
- bus_err  output  1  one-cycle pulse with cpu_ack on an unmapped access.
- mcu_input  input  BUS_WIDTH  switch input, read at address all-ones.
- kb_input  input  BUS_WIDTH  keypad input, read at address all-ones minus 1.
- out_ports  output  NUM_OUT*BUS_WIDTH  output registers; register k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].

Behaviour:
- Reset, asynchronous:
  - FSM to IDLE.
  - cpu_ack=0, bus_err=0, cpu_rdata=0.
  - All out_ports registers=0.
  - RAM contents are not reset.
- Address decode, on the captured address:
  - RAM: addr < DM_DEPTH.
  - OUT k: IO_BASE+k, for k < NUM_OUT.
  - KB: 2^BUS_WIDTH-2.
  - IN: 2^BUS_WIDTH-1.
  - Anything else is unmapped.
- FSM states: IDLE, RAM_WAIT, RESP.
  - IDLE: when cpu_req=1, capture cpu_addr, cpu_wdata and cpu_mw.
    - RAM target with WAIT_STATES>0: load counter with WAIT_STATES and go to RAM_WAIT.
    - All other targets: go to RESP.
  - RAM_WAIT: decrement counter each cycle; when it reaches 1, go to RESP.
  - RESP: perform the access, assert cpu_ack for exactly one cycle, return to IDLE.
- Latency, measured from the cycle cpu_req is first seen high in IDLE to the cpu_ack cycle:
  - IO and unmapped accesses: 1 cycle.
  - RAM accesses: 1+WAIT_STATES cycles.
- A request held high after ack is treated as a new request. It is accepted no earlier than the cycle after ack, because the FSM is back in IDLE.
- Write:
  - RAM: writes the RAM word on the RESP edge.
  - OUT k: updates register k on the RESP edge; visible on out_ports the cycle after ack.
  - IN, KB and unmapped: write ignored.
- Read:
  - cpu_rdata is registered and presented in the ack cycle.
  - RAM returns the stored word.
  - OUT k returns the register readback.
  - IN/KB return the port value sampled at the RESP edge.
  - Unmapped returns 0.
  - cpu_rdata holds its value between acks.
- bus_err: asserted with cpu_ack when the captured address is unmapped, for either read or write.
- Captured fields stay frozen for the whole transaction; mid-transaction changes on the cpu_* inputs are ignored.
- Reset mid-transaction:
  - Transaction abandoned; no ack; no RAM or OUT write.
  - FSM returns to IDLE.
- Address arithmetic: IO_BASE+k uses BUS_WIDTH-bit compare, with no wrap. NUM_OUT <= 14 keeps the OUT window clear of KB and IN.

Optional Feature:
- Macro: MCU_INPUT_SYNC_EN.
- Defined:
  - mcu_input and kb_input each pass through a two-flop synchronizer, reset to 0.
  - A port change is observable by a read no earlier than 2 cycles later.
- Undefined: ports are sampled directly at the RESP edge, with no added latency.

Test Plan:
- RAM write then read, WAIT_STATES=1:
  - Write 8'h5A to addr 8'h10 -> ack 2 cycles after req, bus_err=0.
  - Read addr 8'h10 -> cpu_rdata=8'h5A with ack, 2-cycle latency.
- Output registers:
  - Write 8'h3C to 8'hF0 and 8'hC3 to 8'hF1 -> each acks in 1 cycle.
  - out_ports = 16'hC33C the cycle after the second ack; reading 8'hF1 returns 8'hC3.
- Input ports:
  - mcu_input=8'hA7, kb_input=8'h09.
  - Read 8'hFF -> 8'hA7; read 8'hFE -> 8'h09. With MCU_INPUT_SYNC_EN, a change is reflected only if it occurred 2 or more cycles before RESP.
- Unmapped access:
  - Read 8'h90 -> cpu_rdata=0, bus_err=1 with ack.
  - Write 8'h90 -> bus_err=1, no register or RAM change.
- Reset mid-operation, WAIT_STATES=3:
  - Issue a write of 8'hFF to RAM addr 8'h20, assert rst in the RAM_WAIT state, then release it.
  - Required response: no ack; a subsequent read of 8'h20 returns the pre-write value; out_ports=0.
- Back-to-back requests:
  - Hold cpu_req high across two reads of 8'hF0.
  - Two separate one-cycle ack pulses, separated by at least one non-ack cycle.

Source files
------------

// File: rtl/mcu_bus_controller.sv
// Data-side MCU bus controller: handshaked access to a wait-stated RAM, input ports and output
// registers. Define MCU_INPUT_SYNC_EN to put two-flop synchronizers on mcu_input/kb_input.
module mcu_bus_controller #(
  parameter int unsigned              BUS_WIDTH   = 8,
  parameter int unsigned              DM_DEPTH    = 128,
  parameter logic [BUS_WIDTH-1:0]     IO_BASE     = 8'hF0,
  parameter int unsigned              NUM_OUT     = 2,
  parameter int unsigned              WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_mw,
  input  logic [BUS_WIDTH-1:0]         cpu_addr,
  input  logic [BUS_WIDTH-1:0]         cpu_wdata,
  output logic [BUS_WIDTH-1:0]         cpu_rdata,
  output logic                         cpu_ack,
  output logic                         bus_err,
  input  logic [BUS_WIDTH-1:0]         mcu_input,
  input  logic [BUS_WIDTH-1:0]         kb_input,
  output logic [NUM_OUT*BUS_WIDTH-1:0] out_ports
);

  localparam int unsigned          RAM_AW  = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  localparam logic [BUS_WIDTH-1:0] DM_TOP  = BUS_WIDTH'(DM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] ADDR_IN = {BUS_WIDTH{1'b1}};
  localparam logic [BUS_WIDTH-1:0] ADDR_KB = {{(BUS_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StRamWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] addr_q, wdata_q, rdata_q, rd_data, acc_addr;
  logic                 mw_q, acc_mw, acc_ram, cap, load_rd;
  logic [BUS_WIDTH-1:0] out_q [NUM_OUT];
  logic [NUM_OUT-1:0]   out_hit_q;
  logic                 ram_q, unmapped_q;
  logic [BUS_WIDTH-1:0] mem [DM_DEPTH];
  logic [BUS_WIDTH-1:0] in_s, kb_s;

`ifdef MCU_INPUT_SYNC_EN
  logic [BUS_WIDTH-1:0] in_s1, in_s2, kb_s1, kb_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_s1 <= '0;
      in_s2 <= '0;
      kb_s1 <= '0;
      kb_s2 <= '0;
    end else begin
      in_s1 <= mcu_input;
      in_s2 <= in_s1;
      kb_s1 <= kb_input;
      kb_s2 <= kb_s1;
    end
  end

  assign in_s = in_s2;
  assign kb_s = kb_s2;
`else
  assign in_s = mcu_input;
  assign kb_s = kb_input;
`endif

  // In IDLE the request fields are not captured yet, so decode straight from the bus.
  assign acc_addr = (state_q == StIdle) ? cpu_addr : addr_q;
  assign acc_mw   = (state_q == StIdle) ? cpu_mw : mw_q;
  assign acc_ram  = acc_addr < DM_TOP;

  always_comb begin
    out_hit_q = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (addr_q == IO_BASE + BUS_WIDTH'(k)) out_hit_q[k] = 1'b1;
    end
    ram_q      = addr_q < DM_TOP;
    unmapped_q = !ram_q && (out_hit_q == '0) && (addr_q != ADDR_IN) && (addr_q != ADDR_KB);
  end

  always_comb begin
    rd_data = '0;
    if (acc_ram) begin
      rd_data = mem[acc_addr[RAM_AW-1:0]];
    end else if (acc_addr == ADDR_IN) begin
      rd_data = in_s;
    end else if (acc_addr == ADDR_KB) begin
      rd_data = kb_s;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (acc_addr == IO_BASE + BUS_WIDTH'(k)) rd_data = out_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    load_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          cap = 1'b1;
          if (acc_ram && WAIT_STATES > 0) begin
            state_d = StRamWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StResp;
            load_rd = 1'b1;
          end
        end
      end
      StRamWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          load_rd = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mw_q    <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        mw_q    <= cpu_mw;
      end
      // Read data is registered on the edge entering RESP so it lines up with cpu_ack.
      if (load_rd && !acc_mw) rdata_q <= rd_data;
      if (state_q == StResp && mw_q) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (out_hit_q[k]) out_q[k] <= wdata_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StResp && mw_q && ram_q) mem[addr_q[RAM_AW-1:0]] <= wdata_q;
  end

  always_comb begin
    out_ports = '0;
    for (int k = 0; k < NUM_OUT; k++) out_ports[k*BUS_WIDTH +: BUS_WIDTH] = out_q[k];
  end

  assign cpu_ack   = (state_q == StResp);
  assign bus_err   = cpu_ack && unmapped_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mcu_bus_controller.sv
// Scoreboard bench: dut 0 uses default parameters, dut 1 uses WAIT_STATES=3 for the reset case.
module tb_mcu_bus_controller;

  typedef struct {
    int         dut;
    int         id;
    int         cyc;
    logic [7:0] rdata;
    logic       err;
    logic       chk_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req [2];
  logic        mw [2];
  logic [7:0]  addr [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        ack [2];
  logic        err [2];
  logic [15:0] outp [2];
  logic [7:0]  sw_in, kb_in;

  exp_t sb[$];
  int   cyc = 0;
  int   vid = 0;
  int   nvec = 0;
  int   nfail = 0;

  mcu_bus_controller u0 (
    .clk(clk), .rst(rst[0]), .cpu_req(req[0]), .cpu_mw(mw[0]), .cpu_addr(addr[0]),
    .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]), .cpu_ack(ack[0]), .bus_err(err[0]),
    .mcu_input(sw_in), .kb_input(kb_in), .out_ports(outp[0])
  );

  mcu_bus_controller #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst[1]), .cpu_req(req[1]), .cpu_mw(mw[1]), .cpu_addr(addr[1]),
    .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]), .cpu_ack(ack[1]), .bus_err(err[1]),
    .mcu_input(sw_in), .kb_input(kb_in), .out_ports(outp[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; an ack with nothing queued is a failure.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d]) begin
        if (sb.size() == 0 || sb[0].dut != d) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_ack dut%0d cyc%0d: got ack=1, required ack=0", d, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("v%0d_latency", e.id), cyc, e.cyc);
          chk($sformatf("v%0d_bus_err", e.id), {31'd0, err[d]}, {31'd0, e.err});
          if (e.chk_rd) chk($sformatf("v%0d_rdata", e.id), {24'd0, rdata[d]}, {24'd0, e.rdata});
        end
      end else if (err[d]) begin
        nvec++;
        nfail++;
        $display("FAIL stray_bus_err dut%0d cyc%0d: got err=1, required err=0", d, cyc);
      end
    end
  end

  task automatic wait_ack(input int d, input int n);
    int seen = 0;
    for (int t = 0; t < 40 && seen < n; t++) begin
      @(negedge clk);
      if (ack[d]) seen++;
      else if (n == 1) begin
        // Scramble the bus mid-transaction; the captured fields must be used.
        addr[d]  = ~addr[d];
        wdata[d] = ~wdata[d];
        mw[d]    = ~mw[d];
      end
    end
    req[d] = 1'b0;
    mw[d]  = 1'b0;
    chk($sformatf("dut%0d_ack_count", d), seen, n);
  endtask

  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    @(negedge clk);
    req[d] = 1'b1; mw[d] = w; addr[d] = a; wdata[d] = wd;
    e.dut = d; e.id = vid; e.cyc = cyc + lat; e.rdata = exp_rd; e.err = exp_err; e.chk_rd = !w;
    vid++;
    sb.push_back(e);
    wait_ack(d, 1);
  endtask

  task automatic rd(input int d, input logic [7:0] a, input logic [7:0] exp_rd,
                    input logic exp_err, input int lat);
    xfer(d, 1'b0, a, 8'h00, exp_rd, exp_err, lat);
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [7:0] wd,
                    input logic exp_err, input int lat);
    xfer(d, 1'b1, a, wd, 8'h00, exp_err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; mw[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    sw_in = 8'hA7;
    kb_in = 8'h09;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_ack", {31'd0, ack[0]}, 32'd0);
    chk("reset_rdata", {24'd0, rdata[0]}, 32'd0);
    chk("reset_out_ports", {16'd0, outp[0]}, 32'd0);

    // RAM write/read, one wait state
    wr(0, 8'h10, 8'h5A, 1'b0, 2);
    rd(0, 8'h10, 8'h5A, 1'b0, 2);

    // Output registers
    wr(0, 8'hF0, 8'h3C, 1'b0, 1);
    wr(0, 8'hF1, 8'hC3, 1'b0, 1);
    @(negedge clk);
    chk("out_ports_after_writes", {16'd0, outp[0]}, 32'h0000C33C);
    rd(0, 8'hF1, 8'hC3, 1'b0, 1);
    rd(0, 8'hF0, 8'h3C, 1'b0, 1);

    // Input ports; writes there are ignored
    rd(0, 8'hFF, 8'hA7, 1'b0, 1);
    rd(0, 8'hFE, 8'h09, 1'b0, 1);
    wr(0, 8'hFF, 8'h12, 1'b0, 1);
    rd(0, 8'hFF, 8'hA7, 1'b0, 1);

    // Unmapped accesses, including the first address past RAM and past the OUT window
    rd(0, 8'h90, 8'h00, 1'b1, 1);
    wr(0, 8'h90, 8'hEE, 1'b1, 1);
    rd(0, 8'h10, 8'h5A, 1'b0, 2);
    rd(0, 8'hF0, 8'h3C, 1'b0, 1);
    @(negedge clk);
    chk("out_ports_after_unmapped_write", {16'd0, outp[0]}, 32'h0000C33C);
    wr(0, 8'h7F, 8'h81, 1'b0, 2);
    rd(0, 8'h7F, 8'h81, 1'b0, 2);
    rd(0, 8'h80, 8'h00, 1'b1, 1);
    rd(0, 8'hF2, 8'h00, 1'b1, 1);
    rd(0, 8'hFD, 8'h00, 1'b1, 1);

    // Back-to-back: req held across two reads, acks at +1 and +3
    @(negedge clk);
    req[0] = 1'b1; mw[0] = 1'b0; addr[0] = 8'hF0;
    e.dut = 0; e.rdata = 8'h3C; e.err = 1'b0; e.chk_rd = 1'b1;
    e.id = vid; e.cyc = cyc + 1; vid++; sb.push_back(e);
    e.id = vid; e.cyc = cyc + 3; vid++; sb.push_back(e);
    wait_ack(0, 2);

    // Reset during RAM_WAIT on the three-wait-state instance
    wr(1, 8'h20, 8'h11, 1'b0, 4);
    rd(1, 8'h20, 8'h11, 1'b0, 4);
    wr(1, 8'hF0, 8'h55, 1'b0, 1);
    @(negedge clk);
    chk("w3_out_ports_before_reset", {16'd0, outp[1]}, 32'h00000055);
    req[1] = 1'b1; mw[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 8'hFF;
    @(negedge clk);
    rst[1] = 1'b1;
    req[1] = 1'b0;
    mw[1]  = 1'b0;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("w3_out_ports_after_reset", {16'd0, outp[1]}, 32'd0);
    chk("w3_rdata_after_reset", {24'd0, rdata[1]}, 32'd0);
    rd(1, 8'h20, 8'h11, 1'b0, 4);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
